// File: rtl/prefix_sum_pipe.sv
// Pipelined Kogge-Stone prefix-carry and sum stage: resolves per-bit g/p into a
// registered sum/cout, one beat per cycle under valid/ready with full backpressure.

module prefix_sum_lvl #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_cmb
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
      assign p_o[i] = p_i[i] & p_i[i-DIST];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end
endmodule

module prefix_sum_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err
);
  localparam int STAGES = $clog2(WIDTH);

  logic             adv;
  logic [WIDTH-1:0] p_eff, g_fold;
  logic             err_in;

  logic [STAGES-1:0][WIDTH-1:0] lvl_g_i, lvl_p_i, lvl_g_o, lvl_p_o;
  logic [STAGES-1:0][WIDTH-1:0] g_q, p_q, po_q;
  logic [STAGES-1:0]            ci_q, er_q;
  logic [STAGES:0]              vld_q;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, err_q;

  assign in_ready = !vld_q[STAGES] | out_ready;
  assign adv      = in_ready;

  // Generate wins on an illegal bit: its propagate is dropped everywhere.
  assign p_eff  = p_in & ~g_in;
  assign err_in = |(g_in & p_in);

  always_comb begin
    g_fold    = g_in;
    g_fold[0] = g_in[0] | (p_eff[0] & cin);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    if (k == 0) begin : g_first
      assign lvl_g_i[k] = g_fold;
      assign lvl_p_i[k] = p_eff;
    end else begin : g_next
      assign lvl_g_i[k] = g_q[k-1];
      assign lvl_p_i[k] = p_q[k-1];
    end
    prefix_sum_lvl #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .g_i (lvl_g_i[k]),
      .p_i (lvl_p_i[k]),
      .g_o (lvl_g_o[k]),
      .p_o (lvl_p_o[k])
    );
  end

  // After the last level G[i] is the carry into bit i+1.
  always_comb begin
    sum_d[0] = po_q[STAGES-1][0] ^ ci_q[STAGES-1];
    for (int i = 1; i < WIDTH; i++)
      sum_d[i] = po_q[STAGES-1][i] ^ g_q[STAGES-1][i-1];
    cout_d = g_q[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      g_q    <= '0;
      p_q    <= '0;
      po_q   <= '0;
      ci_q   <= '0;
      er_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (adv) begin
      vld_q   <= {vld_q[STAGES-1:0], in_valid};
      g_q[0]  <= lvl_g_o[0];
      p_q[0]  <= lvl_p_o[0];
      po_q[0] <= p_eff;
      ci_q[0] <= cin;
      er_q[0] <= err_in;
      for (int k = 1; k < STAGES; k++) begin
        g_q[k]  <= lvl_g_o[k];
        p_q[k]  <= lvl_p_o[k];
        po_q[k] <= po_q[k-1];
        ci_q[k] <= ci_q[k-1];
        er_q[k] <= er_q[k-1];
      end
      sum_q  <= sum_d;
      cout_q <= cout_d;
      err_q  <= er_q[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
endmodule
